mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, the data width; the strobe width is DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_req  input  1  instruction-fetch read request; held until if_gnt.
REQ-006 if_addr  input  ADDR_W  fetch address; stable while if_req=1.
REQ-007 if_gnt  output  1  one-cycle pulse, fetch request accepted.
REQ-008 if_rvalid  output  1  one-cycle pulse, fetch response on rdata.
REQ-009 d_req  input  1  data-port request; held until d_gnt.
REQ-010 d_we  input  1  1=store, 0=load.
REQ-011 d_addr  input  ADDR_W  data address.
REQ-012 d_wdata  input  DATA_W  store data.
REQ-013 d_wstrb  input  DATA_W/8  store byte enables.
REQ-014 d_gnt  output  1  one-cycle pulse, data request accepted.
REQ-015 d_rvalid  output  1  one-cycle pulse, load data or store acknowledge.
REQ-016 rdata  output  DATA_W  response data, shared by both requesters, qualified by if_rvalid/d_rvalid.
REQ-017 mem_req  output  1  request to the shared single-port memory.
REQ-018 mem_we, mem_addr, mem_wdata, mem_wstrb  output  1/ADDR_W/DATA_W/DATA_W/8  latched request fields.
REQ-019 mem_gnt  input  1  memory accepted the request this cycle.
REQ-020 mem_rvalid, mem_rdata  input  1/DATA_W  memory response, one per accepted request.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE and WAIT; only one transaction SHALL be outstanding.
REQ-022 In IDLE with any request, the arbiter SHALL pick an owner, latch its fields, pulse the owner's gnt next cycle and enter ISSUE.
REQ-023 On a simultaneous if_req and d_req, the owner SHALL be the requester not granted last (round-robin); a single requester SHALL always win.
REQ-024 In ISSUE, mem_req SHALL be 1 with latched fields until mem_gnt=1, then the FSM SHALL enter WAIT.
REQ-025 In WAIT, on mem_rvalid=1, the block SHALL register mem_rdata into rdata, pulse the owner's rvalid next cycle and return to IDLE.
REQ-026 Minimum latency SHALL be req at cycle 0, gnt at 1, mem_req at 1, rvalid at 3 (with mem_gnt at 1 and mem_rvalid at 2).
REQ-027 Fetch transactions SHALL drive mem_we=0 and mem_wstrb=0.
REQ-028 For a store, d_rvalid SHALL pulse on mem_rvalid and rdata SHALL be 0.
REQ-029 Outside ISSUE, mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb SHALL be 0.
REQ-030 The block SHALL ignore mem_gnt outside ISSUE, mem_rvalid outside WAIT, and new requests outside IDLE.
REQ-031 In the IDLE cycle in which rvalid pulses, a new arbitration SHALL occur, giving 3 cycles per transaction at best.
REQ-032 A request withdrawn before its gnt SHALL receive neither gnt nor rvalid.

Reset
REQ-033 With rst_n=0, the state SHALL be IDLE, all outputs 0 and last-owner = data, so the first conflict goes to fetch.
REQ-034 Reset mid-transaction SHALL abandon the transaction; a late mem_rvalid after release SHALL be ignored.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state encoding, owner encoding (OWN_IF=0, OWN_D=1) and default widths.
REQ-036 The round-robin picker SHALL be sub-module rr_arb2 (inputs req[1:0] and last; output grant index); all other logic SHALL be in mem_arbiter.

Verification
REQ-037 Single fetch: if_addr=0x0000_0004 with mem_gnt immediate and mem_rdata=0x0050_0093 -> if_gnt at cycle 1, if_rvalid at cycle 3 with rdata=0x0050_0093.
REQ-038 Conflict after reset: if_req and d_req both held at cycle 0 -> fetch granted first, data next; the next conflict goes to fetch (alternation).
REQ-039 Store: d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_wstrb=0xF -> mem_* fields match, d_rvalid pulses with rdata=0.
REQ-040 Back-pressure: mem_gnt held low 4 cycles -> mem_req and fields stay stable; no rvalid before mem_rvalid.
REQ-041 rst_n pulled low in WAIT, then mem_rvalid after release -> no rvalid pulse; the next request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arb_pkg
// Brief    : Shared encodings and default widths for the memory arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef logic owner_t;

    localparam owner_t OWN_IF = 1'b0;
    localparam owner_t OWN_D  = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin picker; a lone requester always wins.
// Revision : 1.0
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output owner_t     grant
);

    always_comb begin
        grant = OWN_IF;
        if (req[OWN_IF] && req[OWN_D]) begin
            // On a tie the requester that was not served last goes first.
            grant = (last == OWN_D) ? OWN_IF : OWN_D;
        end else if (req[OWN_D]) begin
            grant = OWN_D;
        end else begin
            grant = OWN_IF;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Fetch/data arbiter onto a single-port memory, one txn in flight.
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,

    output logic [DATA_W-1:0]   rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q,     state_d;
    owner_t              owner_q,     owner_d;
    owner_t              last_q,      last_d;
    logic                we_q,        we_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [STRB_W-1:0]   wstrb_q,     wstrb_d;
    logic                if_gnt_q,    if_gnt_d;
    logic                d_gnt_q,     d_gnt_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q,  d_rvalid_d;
    logic [DATA_W-1:0]   rdata_q,     rdata_d;

    owner_t              pick;
    logic                in_issue;

    rr_arb2 u_rr_arb2 (
        .req   ({d_req, if_req}),
        .last  (last_q),
        .grant (pick)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    owner_d = pick;
                    last_d  = pick;
                    state_d = ST_ISSUE;
                    if (pick == OWN_IF) begin
                        // Fetches are always reads with no byte enables.
                        we_d     = 1'b0;
                        addr_d   = if_addr;
                        wdata_d  = '0;
                        wstrb_d  = '0;
                        if_gnt_d = 1'b1;
                    end else begin
                        we_d     = d_we;
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                        wstrb_d  = d_wstrb;
                        d_gnt_d  = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                if (mem_gnt) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (mem_rvalid) begin
                    // Store acknowledges return zero rather than bus garbage.
                    rdata_d = we_q ? '0 : mem_rdata;
                    state_d = ST_IDLE;
                    if (owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                    end else begin
                        d_rvalid_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_D;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    // Memory-side fields are forced to zero whenever no request is presented.
    assign in_issue  = (state_q == ST_ISSUE);
    assign mem_req   = in_issue;
    assign mem_we    = in_issue ? we_q    : 1'b0;
    assign mem_addr  = in_issue ? addr_q  : '0;
    assign mem_wdata = in_issue ? wdata_q : '0;
    assign mem_wstrb = in_issue ? wstrb_q : '0;

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign rdata     = rdata_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscmp  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- transaction-level reference model ----------------
    // One open transaction at most; it is "accepted" once memory grants it.
    bit          txn_open = 0, txn_acc = 0;
    bit          m_last = 1'b1;           // 0 = fetch, 1 = data
    bit          m_own = 0;
    logic        m_we = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    logic        e_if_gnt = 0, e_d_gnt = 0, e_if_rv = 0, e_d_rv = 0;
    logic [31:0] e_rdata = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            txn_open = 0; txn_acc = 0; m_last = 1'b1;
            m_we = 0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
            e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; e_rdata = '0;
        end else begin
            e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0;
            if (!txn_open) begin
                if (if_req || d_req) begin
                    if (if_req && d_req) m_own = ~m_last;
                    else                 m_own = d_req;
                    m_last = m_own; txn_open = 1; txn_acc = 0;
                    if (m_own == 0) begin
                        m_we = 0; m_addr = if_addr; m_wdata = '0; m_wstrb = '0; e_if_gnt = 1;
                    end else begin
                        m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_wstrb = d_wstrb; e_d_gnt = 1;
                    end
                end
            end else if (!txn_acc) begin
                if (mem_gnt) txn_acc = 1;
            end else if (mem_rvalid) begin
                e_rdata = m_we ? 32'h0 : mem_rdata;
                if (m_own == 0) e_if_rv = 1; else e_d_rv = 1;
                txn_open = 0;
            end
        end
    end

    // ---------------- compare + event log ----------------
    bit          gnt_log[$];
    int          if_gnt_cyc = 0, if_rv_cyc = 0, if_rv_total = 0, d_rv_total = 0, d_gnt_total = 0;
    int          mreq_cycles = 0;
    logic [31:0] if_rv_data = '0, d_rv_data = '0, st_addr = '0, st_wdata = '0;
    logic [3:0]  st_wstrb = '0;

    initial forever begin
        logic exp_mreq;
        @(negedge clk);
        exp_mreq = txn_open && !txn_acc;
        chk("if_gnt",    if_gnt,    e_if_gnt);
        chk("d_gnt",     d_gnt,     e_d_gnt);
        chk("if_rvalid", if_rvalid, e_if_rv);
        chk("d_rvalid",  d_rvalid,  e_d_rv);
        chk("mem_req",   mem_req,   exp_mreq);
        chk("mem_we",    mem_we,    exp_mreq ? m_we : 1'b0);
        chk("mem_addr",  mem_addr,  exp_mreq ? m_addr : 32'h0);
        chk("mem_wdata", mem_wdata, exp_mreq ? m_wdata : 32'h0);
        chk("mem_wstrb", mem_wstrb, exp_mreq ? m_wstrb : 4'h0);
        if (e_if_rv || e_d_rv || !rst_n) chk("rdata", rdata, e_rdata);

        if (if_gnt) begin gnt_log.push_back(1'b0); if_gnt_cyc = cyc; end
        if (d_gnt)  begin gnt_log.push_back(1'b1); d_gnt_total++; end
        if (if_rvalid) begin if_rv_total++; if_rv_cyc = cyc; if_rv_data = rdata; end
        if (d_rvalid)  begin d_rv_total++; d_rv_data = rdata; end
        if (mem_req) begin
            mreq_cycles++;
            if (mem_we) begin st_addr = mem_addr; st_wdata = mem_wdata; st_wstrb = mem_wstrb; end
        end
    end

    // ---------------- memory responder ----------------
    bit          resp_en = 1;
    int          gnt_delay = 0, rv_delay = 0, g_cnt = 0, rv_cnt = 0;
    bit          pend_rv = 0;
    logic [31:0] pend_data = '0;

    initial forever begin
        @(posedge clk); #1;
        if (!resp_en) begin
            pend_rv = 0; g_cnt = 0;
        end else if (!rst_n) begin
            pend_rv = 0; g_cnt = 0; mem_gnt = 0; mem_rvalid = 0;
        end else begin
            mem_gnt = 0; mem_rvalid = 0;
            if (pend_rv) begin
                if (rv_cnt == 0) begin mem_rvalid = 1; mem_rdata = pend_data; pend_rv = 0; end
                else rv_cnt--;
            end else if (mem_req) begin
                if (g_cnt >= gnt_delay) begin
                    mem_gnt = 1; pend_rv = 1; rv_cnt = rv_delay; g_cnt = 0;
                    pend_data = mem_addr ^ 32'h0050_0097;
                end else g_cnt++;
            end
        end
    end

    // ---------------- requester tasks (called #1 after a rising edge) ----------------
    task automatic do_if(input logic [31:0] addr, input bit wait_rv);
        int n; int rv0;
        rv0 = if_rv_total;
        if_addr = addr; if_req = 1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!if_gnt && n < 40);
        chk("if_gnt_timeout", if_gnt, 1'b1);
        if_req = 0; if_addr = '0;
        if (wait_rv) begin
            n = 0;
            while (if_rv_total == rv0 && n < 40) begin @(posedge clk); #1; n++; end
            chk("if_rvalid_timeout", if_rv_total - rv0, 1);
        end
    endtask

    task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input bit wait_rv);
        int n; int rv0;
        rv0 = d_rv_total;
        d_we = we; d_addr = addr; d_wdata = wd; d_wstrb = ws; d_req = 1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!d_gnt && n < 40);
        chk("d_gnt_timeout", d_gnt, 1'b1);
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        if (wait_rv) begin
            n = 0;
            while (d_rv_total == rv0 && n < 40) begin @(posedge clk); #1; n++; end
            chk("d_rvalid_timeout", d_rv_total - rv0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c0; int rv0; int dg0;
        bit exp_order[7];
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_mem_req", mem_req, 1'b0);
        rst_n = 1;
        @(posedge clk); #1;

        // Conflicts straight after reset go to fetch first.
        fork
            do_if(32'h0000_0200, 1);
            do_d(1'b0, 32'h0000_0300, 32'h0, 4'h0, 1);
        join
        fork
            do_if(32'h0000_0204, 1);
            do_d(1'b0, 32'h0000_0304, 32'h0, 4'h0, 1);
        join

        // Single fetch at minimum latency.
        c0 = cyc;
        do_if(32'h0000_0004, 1);
        chk("if_gnt_latency", if_gnt_cyc - c0, 1);
        chk("if_rvalid_latency", if_rv_cyc - c0, 3);
        chk("fetch_rdata", if_rv_data, 32'h0050_0093);

        // Fetch was served last, so this conflict goes to data.
        fork
            do_if(32'h0000_0208, 1);
            do_d(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1);
        join
        chk("load_rdata", d_rv_data, 32'h0050_00D7);
        chk("grant_log_len", gnt_log.size(), 7);
        for (int i = 0; i < 7 && i < gnt_log.size(); i++)
            chk($sformatf("grant_order[%0d]", i), gnt_log[i], exp_order[i]);

        // Store.
        do_d(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1);
        chk("store_addr", st_addr, 32'h0000_0100);
        chk("store_wdata", st_wdata, 32'hDEAD_BEEF);
        chk("store_wstrb", st_wstrb, 4'hF);
        chk("store_rdata", d_rv_data, 32'h0);

        // Back-pressure with a data request raised and withdrawn while busy.
        gnt_delay = 4;
        mreq_cycles = 0;
        dg0 = d_gnt_total;
        fork
            do_if(32'h0000_0080, 1);
            begin
                repeat (2) @(posedge clk);
                #1; d_req = 1; d_we = 1; d_addr = 32'h999;
                @(posedge clk);
                #1; d_req = 0; d_we = 0; d_addr = '0;
            end
        join
        chk("bp_mem_req_cycles", mreq_cycles, 5);
        chk("withdrawn_no_gnt", d_gnt_total - dg0, 0);
        chk("bp_rdata", if_rv_data, 32'h0050_0017);
        gnt_delay = 0;

        // Reset while waiting for the response, then a late response.
        rv_delay = 3;
        rv0 = if_rv_total + d_rv_total;
        do_if(32'h0000_0010, 0);
        @(posedge clk); #1;
        resp_en = 0; mem_gnt = 0; mem_rvalid = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1;
        @(posedge clk); #1;
        mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_rvalid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("late_rvalid_ignored", (if_rv_total + d_rv_total) - rv0, 0);
        rv_delay = 0; resp_en = 1;
        @(posedge clk); #1;
        do_if(32'h0000_0014, 1);
        chk("post_reset_rdata", if_rv_data, 32'h0050_0083);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
